pl_sysref_seq: RTL and testbench

PL_SYSREF_SEQ -- requirements
Module: pl_sysref_seq

---
 rtl/pl_sysref_pkg.sv | 21 ++
 rtl/pl_sysref_period_meas.sv | 67 ++++++
 rtl/pl_sysref_seq.sv | 165 ++++++++++++++++
 tb/tb_pl_sysref_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_sysref_pkg.sv
// ----------------------------------------------------------------------------
// pl_sysref_pkg : shared state encoding and defaults for the SYSREF sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pl_sysref_pkg;

  localparam int C_PERIOD_W   = 16;
  localparam int C_LOCK_COUNT = 4;

  localparam logic [2:0] C_ST_SEARCH  = 3'd0;
  localparam logic [2:0] C_ST_MEASURE = 3'd1;
  localparam logic [2:0] C_ST_LOCKED  = 3'd2;
  localparam logic [2:0] C_ST_ARMED   = 3'd3;
  localparam logic [2:0] C_ST_GATE    = 3'd4;
  localparam logic [2:0] C_ST_DONE    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/pl_sysref_period_meas.sv
// ----------------------------------------------------------------------------
// pl_sysref_period_meas : SYSREF edge detector, period counter and match logic
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pl_sysref_period_meas
  import pl_sysref_pkg::*;
#(
  parameter int PERIOD_W = C_PERIOD_W
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic                i_sysref,
  output logic                o_s1,
  output logic                o_edge,
  output logic                o_match,
  output logic                o_sat,
  output logic [PERIOD_W-1:0] o_period
);

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                w_edge;
  logic                w_sat;

  always_comb begin
    s1_d     = i_sysref;
    s2_d     = s1_q;
    w_edge   = s1_q & ~s2_q;
    w_sat    = &cnt_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    // An edge restarts the count at 1 so the value seen on the next edge is the full period
    if (w_edge) begin
      cnt_d    = PERIOD_W'(1);
      period_d = cnt_q;
    end else if (!w_sat) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge pl_clk or posedge pl_rst) begin
    if (pl_rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign o_s1     = s1_q;
  assign o_edge   = w_edge;
  assign o_match  = (cnt_q == period_q);
  assign o_sat    = w_sat;
  assign o_period = period_q;

endmodule

`default_nettype wire

// File: rtl/pl_sysref_seq.sv
// ----------------------------------------------------------------------------
// pl_sysref_seq : SYSREF period lock detector and gated burst sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pl_sysref_seq
  import pl_sysref_pkg::*;
#(
  parameter int PERIOD_W   = C_PERIOD_W,
  parameter int LOCK_COUNT = C_LOCK_COUNT
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic                pl_sysref_captured,
  input  logic                arm,
  input  logic [7:0]          num_pulses,
  output logic                user_sysref_out,
  output logic                locked,
  output logic                busy,
  output logic                done,
  output logic                err_unlock,
  output logic [PERIOD_W-1:0] period
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);

  logic            w_s1;
  logic            w_edge;
  logic            w_match;
  logic            w_sat;
  logic            w_lost;
  logic            w_gate_en;

  logic [2:0]      state_q, state_d;
  logic [MC_W-1:0] mc_q, mc_d;
  logic [7:0]      num_q, num_d;
  logic [7:0]      pc_q, pc_d;
  logic            err_unlock_q, err_unlock_d;
  logic            sysref_out_q, sysref_out_d;

  pl_sysref_period_meas #(
    .PERIOD_W (PERIOD_W)
  ) u_meas (
    .pl_clk   (pl_clk),
    .pl_rst   (pl_rst),
    .i_sysref (pl_sysref_captured),
    .o_s1     (w_s1),
    .o_edge   (w_edge),
    .o_match  (w_match),
    .o_sat    (w_sat),
    .o_period (period)
  );

  always_comb begin
    state_d      = state_q;
    mc_d         = mc_q;
    num_d        = num_q;
    pc_d         = pc_q;
    err_unlock_d = err_unlock_q;
    w_gate_en    = 1'b0;
    w_lost       = w_edge & ~w_match;

    // A saturated counter means SYSREF vanished; this overrides every state
    if (w_sat) begin
      state_d = C_ST_SEARCH;
      mc_d    = '0;
      if (state_q == C_ST_ARMED || state_q == C_ST_GATE) begin
        err_unlock_d = 1'b1;
      end
    end else begin
      case (state_q)
        C_ST_SEARCH: begin
          if (w_edge) begin
            state_d = C_ST_MEASURE;
            mc_d    = '0;
          end
        end
        C_ST_MEASURE: begin
          if (w_edge) begin
            if (w_match) begin
              mc_d = mc_q + MC_W'(1);
              if (mc_q == MC_W'(LOCK_COUNT - 1)) begin
                state_d = C_ST_LOCKED;
              end
            end else begin
              mc_d = '0;
            end
          end
        end
        C_ST_LOCKED: begin
          if (w_lost) begin
            state_d = C_ST_SEARCH;
          end else if (arm) begin
            state_d      = C_ST_ARMED;
            num_d        = num_pulses;
            err_unlock_d = 1'b0;
          end
        end
        C_ST_ARMED: begin
          if (w_lost) begin
            state_d      = C_ST_SEARCH;
            err_unlock_d = 1'b1;
          end else if (num_q == 8'd0) begin
            state_d = C_ST_DONE;
          end else if (w_edge) begin
            state_d   = C_ST_GATE;
            pc_d      = 8'd1;
            w_gate_en = 1'b1;
          end
        end
        C_ST_GATE: begin
          if (w_lost) begin
            state_d      = C_ST_SEARCH;
            err_unlock_d = 1'b1;
          end else if (w_edge && (pc_q == num_q)) begin
            // Terminating edge: its pulse is withheld
            state_d = C_ST_DONE;
          end else begin
            w_gate_en = 1'b1;
            if (w_edge) begin
              pc_d = pc_q + 8'd1;
            end
          end
        end
        C_ST_DONE: begin
          state_d = C_ST_LOCKED;
        end
        default: begin
          state_d = C_ST_SEARCH;
        end
      endcase
    end

    sysref_out_d = w_s1 & w_gate_en;
  end

  always_ff @(posedge pl_clk or posedge pl_rst) begin
    if (pl_rst) begin
      state_q      <= C_ST_SEARCH;
      mc_q         <= '0;
      num_q        <= '0;
      pc_q         <= '0;
      err_unlock_q <= 1'b0;
      sysref_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mc_q         <= mc_d;
      num_q        <= num_d;
      pc_q         <= pc_d;
      err_unlock_q <= err_unlock_d;
      sysref_out_q <= sysref_out_d;
    end
  end

  assign user_sysref_out = sysref_out_q;
  assign err_unlock      = err_unlock_q;
  assign busy            = (state_q == C_ST_ARMED) || (state_q == C_ST_GATE);
  assign done            = (state_q == C_ST_DONE);
  assign locked          = (state_q == C_ST_LOCKED) || (state_q == C_ST_ARMED) ||
                           (state_q == C_ST_GATE)   || (state_q == C_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pl_sysref_seq.sv
// ----------------------------------------------------------------------------
// tb_pl_sysref_seq : directed stimulus with a behavioural reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pl_sysref_seq;

  localparam int LOCK_N = 4;
  localparam int SATV   = 65535;

  logic        pl_clk;
  logic        pl_rst;
  logic        pl_sysref_captured;
  logic        arm;
  logic [7:0]  num_pulses;
  logic        user_sysref_out;
  logic        locked;
  logic        busy;
  logic        done;
  logic        err_unlock;
  logic [15:0] period;

  int n_tot = 0;
  int n_bad = 0;
  int ncyc  = 0;
  int sr_en = 0;
  int sr_ph = 0;
  int sr_per = 32;

  pl_sysref_seq dut (
    .pl_clk             (pl_clk),
    .pl_rst             (pl_rst),
    .pl_sysref_captured (pl_sysref_captured),
    .arm                (arm),
    .num_pulses         (num_pulses),
    .user_sysref_out    (user_sysref_out),
    .locked             (locked),
    .busy               (busy),
    .done               (done),
    .err_unlock         (err_unlock),
    .period             (period)
  );

  initial begin
    pl_clk = 1'b0;
    forever #5 pl_clk = ~pl_clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
    end
  endtask

  // Reference model: phases named by intent, period measured from edge timestamps
  typedef enum int {M_HUNT, M_QUAL, M_HOLD, M_WAIT, M_PASS, M_END} mph_t;
  mph_t mph  = M_HUNT;
  int   u    = 0;
  int   org  = 1;
  int   m_per = 0;
  int   run  = 0;
  int   rem  = 0;
  bit   m_s1 = 0, m_s2 = 0, m_out = 0, m_err = 0;

  always @(posedge pl_clk or posedge pl_rst) begin
    int   cnt;
    bit   ed, mt, g;
    mph_t nph;
    if (pl_rst) begin
      mph = M_HUNT; u = 0; org = 1; m_per = 0; run = 0; rem = 0;
      m_s1 = 0; m_s2 = 0; m_out = 0; m_err = 0;
    end else begin
      u++;
      cnt = (u - org > SATV) ? SATV : (u - org);
      ed  = m_s1 && !m_s2;
      mt  = (cnt == m_per);
      g   = 0;
      nph = mph;
      if (cnt == SATV) begin
        nph = M_HUNT; run = 0;
        if (mph == M_WAIT || mph == M_PASS) m_err = 1;
      end else begin
        case (mph)
          M_HUNT: if (ed) begin nph = M_QUAL; run = 0; end
          M_QUAL: if (ed) begin
            if (mt) begin
              run++;
              if (run == LOCK_N) nph = M_HOLD;
            end else run = 0;
          end
          M_HOLD: if (ed && !mt) nph = M_HUNT;
                  else if (arm) begin rem = num_pulses; m_err = 0; nph = M_WAIT; end
          M_WAIT: if (ed && !mt) begin nph = M_HUNT; m_err = 1; end
                  else if (rem == 0) nph = M_END;
                  else if (ed) begin g = 1; rem--; nph = M_PASS; end
          M_PASS: if (ed && !mt) begin nph = M_HUNT; m_err = 1; end
                  else if (ed && rem == 0) nph = M_END;
                  else begin g = 1; if (ed) rem--; end
          M_END:  nph = M_HOLD;
          default: nph = M_HUNT;
        endcase
      end
      m_out = m_s1 && g;
      if (ed) begin org = u; m_per = cnt; end
      m_s2 = m_s1;
      m_s1 = pl_sysref_captured;
      mph  = nph;
    end
  end

  always @(negedge pl_clk) begin
    chk("out",    int'(user_sysref_out), int'(m_out));
    chk("locked", int'(locked), int'(mph == M_HOLD || mph == M_WAIT || mph == M_PASS || mph == M_END));
    chk("busy",   int'(busy),   int'(mph == M_WAIT || mph == M_PASS));
    chk("done",   int'(done),   int'(mph == M_END));
    chk("err",    int'(err_unlock), int'(m_err));
    chk("period", int'(period), m_per);
  end

  task automatic tick();
    @(posedge pl_clk);
    ncyc++;
    #1;
    arm = 1'b0;
    if (sr_en != 0) sr_ph = (sr_ph >= sr_per - 1) ? 0 : sr_ph + 1;
    pl_sysref_captured = (sr_en != 0) && (sr_ph < 4);
  endtask

  task automatic run_to(input int target);
    while (ncyc < target) tick();
  endtask

  initial begin
    int rises, his, first_hi, seen;
    bit prev;
    pl_rst = 1'b1; pl_sysref_captured = 1'b0; arm = 1'b0; num_pulses = 8'd0;
    repeat (3) @(posedge pl_clk);
    #1;
    chk("rst_out", int'(user_sysref_out), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_unlock), 0);
    chk("rst_period", int'(period), 0);
    pl_rst = 1'b0;
    ncyc = 0;

    // First rise lands so the reset-to-edge interval is also 32; edges at 33,65,..,161
    run_to(30);
    sr_en = 1; sr_ph = 31;
    run_to(160);
    chk("lock_not_yet", int'(locked), 0);
    tick();
    chk("lock_rise", int'(locked), 1);
    chk("lock_period", int'(period), 32);

    // Burst of 3: edges at 193,225,257 pass, 289 terminates
    run_to(170);
    arm = 1'b1; num_pulses = 8'd3;
    rises = 0; his = 0; first_hi = -1; prev = 0;
    while (ncyc < 299) begin
      tick();
      if (user_sysref_out) begin
        his++;
        if (!prev) begin rises++; if (first_hi < 0) first_hi = ncyc; end
      end
      prev = user_sysref_out;
      if (ncyc == 289) chk("burst_done", int'(done), 1);
      if (ncyc == 290) chk("burst_busy_after", int'(busy), 0);
    end
    chk("burst_first_out", first_hi, 193);
    chk("burst_rises", rises, 3);
    chk("burst_high_cycles", his, 12);

    // Zero-length burst
    run_to(300);
    arm = 1'b1; num_pulses = 8'd0;
    his = 0;
    while (ncyc < 339) begin
      tick();
      if (user_sysref_out) his++;
      if (ncyc == 301) chk("zero_done_early", int'(done), 0);
      if (ncyc == 302) chk("zero_done", int'(done), 1);
      if (ncyc == 303) chk("zero_done_late", int'(done), 0);
    end
    chk("zero_no_pulse", his, 0);

    // Burst of 5 broken by a 30-cycle period (edge at 383)
    run_to(340);
    arm = 1'b1; num_pulses = 8'd5;
    run_to(360);
    sr_per = 30;
    run_to(383);
    chk("unlock_err", int'(err_unlock), 1);
    chk("unlock_locked", int'(locked), 0);
    sr_per = 32;
    while (ncyc < 388) begin
      tick();
      chk("unlock_out_low", int'(user_sysref_out), 0);
    end

    // Relock at 543; err stays until an accepted arm
    run_to(550);
    chk("sticky_locked", int'(locked), 1);
    chk("sticky_err", int'(err_unlock), 1);
    arm = 1'b1; num_pulses = 8'd1;
    tick();
    chk("err_cleared", int'(err_unlock), 0);

    // SYSREF stops; last edge at 607, saturation at 607+65535
    run_to(620);
    sr_en = 0;
    run_to(66141);
    chk("sat_still_locked", int'(locked), 1);
    tick();
    chk("sat_search", int'(locked), 0);
    run_to(66200);
    sr_en = 1; sr_ph = 31;
    run_to(66380);
    chk("relock", int'(locked), 1);
    chk("relock_period", int'(period), 32);

    // Reset while a gated pulse is high
    arm = 1'b1; num_pulses = 8'd3;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick();
      if (user_sysref_out) seen = 1;
    end
    chk("burst_started", seen, 1);
    tick();
    #2;
    pl_rst = 1'b1;
    #1;
    chk("async_rst_out", int'(user_sysref_out), 0);
    chk("async_rst_locked", int'(locked), 0);
    tick();
    tick();
    pl_rst = 1'b0;
    tick();
    chk("post_rst_locked", int'(locked), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_out", int'(user_sysref_out), 0);
    repeat (100) tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
